// File: rtl/apb2axi_wr_packer.sv
// Packs per-tag APB word pulses into AXI-width write beats and queues them,
// tagged and LAST-marked, in a shared output FIFO for the W-channel builder.
module apb2axi_wr_packer #(
  parameter int TAG_NUM    = 16,
  parameter int TAG_W      = 4,
  parameter int APB_DATA_W = 32,
  parameter int AXI_DATA_W = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            pclk,
  input  logic                            preset,
  input  logic                            wr_word_valid,
  input  logic [TAG_W-1:0]                wr_word_tag,
  input  logic [APB_DATA_W-1:0]           wr_word_data,
  input  logic                            alloc_vld,
  input  logic [TAG_W-1:0]                alloc_tag,
  input  logic [7:0]                      alloc_len,
  output logic                            wpk_beat_valid,
  input  logic                            wpk_beat_ready,
  output logic [TAG_W-1:0]                wpk_beat_tag,
  output logic [AXI_DATA_W-1:0]           wpk_beat_data,
  output logic [AXI_DATA_W/8-1:0]         wpk_beat_strb,
  output logic                            wpk_beat_last,
  output logic                            wpk_tag_done,
  output logic [TAG_W-1:0]                wpk_tag_done_tag,
  output logic                            wpk_err,
  output logic                            wpk_ovf_sticky,
  output logic [$clog2(FIFO_DEPTH):0]     wpk_fifo_level
);
  localparam int N  = AXI_DATA_W / APB_DATA_W;
  localparam int SW = (N > 1) ? N - 1 : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic {IDLE, FILL} ctx_st_e;

  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [AXI_DATA_W-1:0] data;
    logic                  last;
  } beat_t;

  ctx_st_e                          st_q   [TAG_NUM];
  ctx_st_e                          st_d   [TAG_NUM];
  logic [IW-1:0]                    idx_q  [TAG_NUM];
  logic [7:0]                       cnt_q  [TAG_NUM];
  logic [7:0]                       len_q  [TAG_NUM];
  logic [SW-1:0][APB_DATA_W-1:0]    stg_q  [TAG_NUM];

  beat_t                            mem    [FIFO_DEPTH];
  logic [PW-1:0]                    wr_ptr, rd_ptr;
  logic [LW-1:0]                    fifo_cnt;

  logic w_fill, w_drop, beat_done, beat_last, a_ok, a_rej;
  logic pop, push, full, ovf;
  logic [AXI_DATA_W-1:0] beat_data;

  // Current word always lands in the top lane; earlier lanes come from staging.
  if (N > 1) begin : g_stg
    assign beat_data = {wr_word_data, stg_q[wr_word_tag]};
  end else begin : g_nostg
    assign beat_data = wr_word_data;
  end

  always_comb begin
    w_fill    = wr_word_valid && (st_q[wr_word_tag] == FILL);
    w_drop    = wr_word_valid && (st_q[wr_word_tag] == IDLE);
    beat_done = w_fill && (idx_q[wr_word_tag] == IW'(N - 1));
    beat_last = beat_done && (cnt_q[wr_word_tag] == len_q[wr_word_tag]);
    a_ok      = alloc_vld && (st_q[alloc_tag] == IDLE);
    a_rej     = alloc_vld && (st_q[alloc_tag] == FILL);
    pop       = (fifo_cnt != '0) && wpk_beat_ready;
    full      = (fifo_cnt == LW'(FIFO_DEPTH));
    push      = beat_done && (!full || pop);
    ovf       = beat_done && !push;
  end

  // Word and alloc both judge the pre-cycle state, so they never fight over one tag.
  always_comb begin
    for (int i = 0; i < TAG_NUM; i++) st_d[i] = st_q[i];
    if (beat_last) st_d[wr_word_tag] = IDLE;
    if (a_ok)      st_d[alloc_tag]   = FILL;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < TAG_NUM; i++) begin
        st_q[i]  <= IDLE;
        idx_q[i] <= '0;
        cnt_q[i] <= '0;
        len_q[i] <= '0;
        stg_q[i] <= '0;
      end
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_cnt         <= '0;
      wpk_err          <= 1'b0;
      wpk_tag_done     <= 1'b0;
      wpk_tag_done_tag <= '0;
      wpk_ovf_sticky   <= 1'b0;
    end else begin
      for (int i = 0; i < TAG_NUM; i++) st_q[i] <= st_d[i];
      if (w_fill) begin
        if (beat_done) begin
          idx_q[wr_word_tag] <= '0;
          cnt_q[wr_word_tag] <= cnt_q[wr_word_tag] + 8'd1;
        end else begin
          for (int l = 0; l < SW; l++)
            if (idx_q[wr_word_tag] == IW'(l)) stg_q[wr_word_tag][l] <= wr_word_data;
          idx_q[wr_word_tag] <= idx_q[wr_word_tag] + 1'b1;
        end
      end
      if (a_ok) begin
        idx_q[alloc_tag] <= '0;
        cnt_q[alloc_tag] <= '0;
        len_q[alloc_tag] <= alloc_len;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt         <= fifo_cnt + LW'(push) - LW'(pop);
      wpk_err          <= w_drop || a_rej || ovf;
      // A dropped final beat still closes the burst.
      wpk_tag_done     <= beat_last;
      wpk_tag_done_tag <= beat_last ? wr_word_tag : '0;
      if (ovf) wpk_ovf_sticky <= 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr] <= '{tag: wr_word_tag, data: beat_data, last: beat_last};
  end

  assign wpk_beat_valid = (fifo_cnt != '0);
  assign wpk_beat_tag   = wpk_beat_valid ? mem[rd_ptr].tag  : '0;
  assign wpk_beat_data  = wpk_beat_valid ? mem[rd_ptr].data : '0;
  assign wpk_beat_last  = wpk_beat_valid ? mem[rd_ptr].last : 1'b0;
  assign wpk_beat_strb  = {(AXI_DATA_W/8){wpk_beat_valid}};
  assign wpk_fifo_level = fifo_cnt;

endmodule
